axis_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one AXI-Stream sink (typically an axis_fifo) among NUM_PORTS
//   AXI-Stream sources. Grants one source at a time and holds the grant for a whole packet
//   (until the tlast beat is accepted). Tags the output stream with the granted port index in
//   tid so a downstream demux can route it. Sits directly in front of the shared FIFO.

---
 rtl/axis_rr_arbiter.sv | 99 +++++++++
 tb/tb_axis_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: grants one source per packet (or per beat when LAST_ENABLE=0)
// and tags the shared output stream with the granted port index in m_axis_tid.
module axis_rr_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned LAST_ENABLE = 1,
  localparam int unsigned GNT_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [GNT_WIDTH-1:0]            m_axis_tid,
  input  logic                            m_axis_tready,
  output logic                            busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               state_q;
  logic [GNT_WIDTH-1:0] gnt_q;
  logic [GNT_WIDTH-1:0] last_gnt_q;
  logic [GNT_WIDTH-1:0] winner;
  logic                 found;
  logic [31:0]          idx;
  logic                 src_valid;
  logic                 src_last;
  logic                 release_pkt;

  // Search for the first requester starting just after the last served port.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = 32'(last_gnt_q) + 32'(i);
      if (idx >= 32'(NUM_PORTS)) idx = idx - 32'(NUM_PORTS);
      if (!found && s_axis_tvalid[idx[GNT_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = idx[GNT_WIDTH-1:0];
      end
    end
  end

  // Output mux driven by the current grant; only the granted port sees sink ready.
  always_comb begin
    m_axis_tdata  = '0;
    src_valid     = 1'b0;
    src_last      = 1'b0;
    s_axis_tready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt_q == GNT_WIDTH'(p)) begin
        m_axis_tdata = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        src_valid    = s_axis_tvalid[p];
        src_last     = s_axis_tlast[p];
      end
    end
    if (state_q == GRANT) s_axis_tready[gnt_q] = m_axis_tready;
    m_axis_tvalid = (state_q == GRANT) && src_valid;
    m_axis_tlast  = (LAST_ENABLE != 0) ? src_last : 1'b1;
    m_axis_tid    = gnt_q;
    busy          = (state_q == GRANT);
    release_pkt   = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  end

  // After reset last_gnt points at the top port so port 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= GNT_WIDTH'(NUM_PORTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q   <= winner;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_pkt) begin
            last_gnt_q <= gnt_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: packet mode (4 ports) plus a per-beat (LAST_ENABLE=0) instance.
module tb_axis_rr_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned GW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NP*DW-1:0]   s_tdata;
  logic [NP-1:0]      s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]      m_tdata;
  logic               m_tvalid, m_tlast, m_tready, busy;
  logic [GW-1:0]      m_tid;

  logic               rst2;
  logic [NP*DW-1:0]   s2_tdata;
  logic [NP-1:0]      s2_tvalid, s2_tlast, s2_tready;
  logic [DW-1:0]      m2_tdata;
  logic               m2_tvalid, m2_tlast, m2_tready, busy2;
  logic [GW-1:0]      m2_tid;

  logic [NP-1:0]      src_en;
  logic [7:0]         src_len [NP];
  logic [7:0]         beat_q  [NP];
  logic [7:0]         pkt_q   [NP];

  int n_cmp = 0;
  int n_err = 0;

  axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .LAST_ENABLE(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tready(m_tready), .busy(busy)
  );

  axis_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .LAST_ENABLE(0)) dut_nl (
    .clk(clk), .rst(rst2),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tlast(s2_tlast),
    .s_axis_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tlast(m2_tlast),
    .m_axis_tid(m2_tid), .m_axis_tready(m2_tready), .busy(busy2)
  );

  assign s2_tdata = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
  assign s2_tlast = '0;

  // Packet sources: data word encodes {port, packet number, beat number}.
  always_comb begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    for (int p = 0; p < int'(NP); p++) begin
      s_tvalid[p]          = src_en[p];
      s_tlast[p]           = (beat_q[p] == src_len[p] - 8'd1);
      s_tdata[p*DW +: DW]  = {8'(p), pkt_q[p], 8'h00, beat_q[p]};
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < int'(NP); p++) begin
      if (!rst) begin
        beat_q[p] <= '0;
        pkt_q[p]  <= '0;
      end else if (s_tvalid[p] && s_tready[p]) begin
        if (s_tlast[p]) begin
          beat_q[p] <= '0;
          pkt_q[p]  <= pkt_q[p] + 8'd1;
        end else begin
          beat_q[p] <= beat_q[p] + 8'd1;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_data(input int p, input int pkt, input int bt);
    return {8'(p), 8'(pkt), 8'h00, 8'(bt)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_busy"},   64'(busy),     64'd0);
  endtask

  task automatic chk_beat(input string tag, input int port, input int pkt, input int bt,
                          input logic last);
    #1;
    chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd1);
    chk({tag, "_tid"},    64'(m_tid),    64'(port));
    chk({tag, "_tdata"},  64'(m_tdata),  64'(exp_data(port, pkt, bt)));
    chk({tag, "_tlast"},  64'(m_tlast),  64'(last));
    chk({tag, "_tready"}, 64'(s_tready), 64'(4'b0001 << port));
    chk({tag, "_busy"},   64'(busy),     64'd1);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    src_en = '0;
    tick();
    tick();
  endtask

  int             pk, bt, eport;
  logic           stalled;
  logic [DW-1:0]  held_d;
  logic [GW-1:0]  held_id;
  logic           held_l;

  initial begin
    rst       = 1'b0;
    rst2      = 1'b0;
    src_en    = '0;
    m_tready  = 1'b1;
    m2_tready = 1'b1;
    s2_tvalid = '0;
    for (int p = 0; p < int'(NP); p++) src_len[p] = 8'd3;
    tick();

    // Reset held with all ports requesting
    src_en = '1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("t1");
      chk("t1_tid", 64'(m_tid), 64'd0);
    end

    // All ports, 3-beat packets: tid 0,1,2,3,0,... with one idle cycle between packets
    rst = 1'b1;
    chk_idle("t2_first_idle");
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 3; b++) begin
        tick();
        chk_beat("t2", k % 4, k / 4, b, (b == 2));
      end
      tick();
      chk_idle("t2_gap");
    end

    // Port 2 alone (5 beats), port 1 joins mid-packet and must wait
    tick();
    do_reset();
    src_len[2] = 8'd5;
    src_len[1] = 8'd2;
    rst        = 1'b1;
    src_en     = 4'b0100;
    chk_idle("t3_idle0");
    tick();
    src_en = 4'b0110;
    chk_beat("t3_p2", 2, 0, 0, 1'b0);
    for (int b = 1; b < 5; b++) begin
      tick();
      chk_beat("t3_p2", 2, 0, b, (b == 4));
    end
    tick();
    chk_idle("t3_gap1");
    tick();
    chk_beat("t3_p1", 1, 0, 0, 1'b0);
    tick();
    chk_beat("t3_p1", 1, 0, 1, 1'b1);
    tick();
    chk_idle("t3_gap2");
    tick();
    chk_beat("t3_p2_again", 2, 1, 0, 1'b0);

    // Random sink backpressure, ports 0 and 3 with 8-beat packets
    tick();
    do_reset();
    src_len[0] = 8'd8;
    src_len[3] = 8'd8;
    src_en     = 4'b1001;
    rst        = 1'b1;
    pk = 0; bt = 0; stalled = 1'b0;
    held_d = '0; held_id = '0; held_l = 1'b0;
    for (int cyc = 0; cyc < 400 && pk < 4; cyc++) begin
      m_tready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        chk("t4_hold_tvalid", 64'(m_tvalid), 64'd1);
        chk("t4_hold_tdata",  64'(m_tdata),  64'(held_d));
        chk("t4_hold_tid",    64'(m_tid),    64'(held_id));
        chk("t4_hold_tlast",  64'(m_tlast),  64'(held_l));
      end
      if (m_tvalid && m_tready) begin
        eport = (pk % 2 == 0) ? 0 : 3;
        chk("t4_tid",   64'(m_tid),   64'(eport));
        chk("t4_tdata", 64'(m_tdata), 64'(exp_data(eport, pk / 2, bt)));
        chk("t4_tlast", 64'(m_tlast), 64'(bt == 7));
        if (bt == 7) begin
          bt = 0;
          pk++;
        end else begin
          bt++;
        end
      end
      stalled = m_tvalid && !m_tready;
      held_d  = m_tdata;
      held_id = m_tid;
      held_l  = m_tlast;
      tick();
    end
    chk("t4_packets_done", 64'(pk), 64'd4);
    m_tready = 1'b1;

    // Reset on beat 2 of a 4-beat packet from port 1; afterwards port 0 wins
    do_reset();
    src_len[0] = 8'd2;
    src_len[1] = 8'd4;
    src_en     = 4'b0010;
    rst        = 1'b1;
    chk_idle("t5_idle0");
    for (int b = 0; b < 3; b++) begin
      tick();
      chk_beat("t5_p1", 1, 0, b, 1'b0);
    end
    rst    = 1'b0;
    src_en = 4'b0011;
    tick();
    chk_idle("t5_after_rst");
    tick();
    rst = 1'b1;
    chk_idle("t5_release_idle");
    tick();
    chk_beat("t5_p0_wins", 0, 0, 0, 1'b0);

    // Per-beat arbitration: ports 0 and 1 alternate with an idle cycle, tlast forced high
    s2_tvalid = 4'b0011;
    tick();
    rst2 = 1'b1;
    #1;
    chk("t6_idle_tvalid", 64'(m2_tvalid), 64'd0);
    chk("t6_idle_busy",   64'(busy2),     64'd0);
    for (int r = 0; r < 6; r++) begin
      tick();
      #1;
      chk("t6_tvalid", 64'(m2_tvalid), 64'd1);
      chk("t6_tid",    64'(m2_tid),    64'(r % 2));
      chk("t6_tdata",  64'(m2_tdata),  64'(32'h0000_00A0 + 32'(r % 2)));
      chk("t6_tlast",  64'(m2_tlast),  64'd1);
      chk("t6_tready", 64'(s2_tready), 64'(4'b0001 << (r % 2)));
      tick();
      #1;
      chk("t6_gap_tvalid", 64'(m2_tvalid), 64'd0);
      chk("t6_gap_busy",   64'(busy2),     64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
